jpeg_blk_sched: RTL and testbench

- Frame-level block scheduler for the JPEG entropy path.
- Pulls 8x8 quantized-coefficient blocks (64 zigzag coefficients each) from three component sources (Y, Cb, Cr) in MCU order.
- Serializes them into the single shared run-length stage (11b q_data/q_data_valid stream) and brackets each frame with frame_start/frame_end pulses.
- Outputs a component id aligned with the data for Huffman table and DC-predictor selection downstream.

---
 rtl/jpeg_pkg.sv | 28 ++
 rtl/jpeg_mcu_seq.sv | 56 +++++
 rtl/jpeg_blk_sched.sv | 159 +++++++++++++++
 tb/tb_jpeg_blk_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_pkg : shared constants for the JPEG entropy-path block scheduler |
// | Rev 1.0  : initial release                                            |
// +----------------------------------------------------------------------+
package jpeg_pkg;

  typedef logic [1:0] comp_t;

  localparam comp_t COMP_Y  = 2'd0;
  localparam comp_t COMP_CB = 2'd1;
  localparam comp_t COMP_CR = 2'd2;

  localparam logic MODE_444 = 1'b0;
  localparam logic MODE_420 = 1'b1;

  localparam int BLK_COEFS = 64;
  localparam int COEF_W    = 11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ARB   = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_END   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/jpeg_mcu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_mcu_seq : MCU slot counter and component sequence lookup         |
// | Rev 1.0      : initial release                                        |
// +----------------------------------------------------------------------+
module jpeg_mcu_seq
  import jpeg_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  mode,
  input  logic  clr,
  input  logic  adv,
  output comp_t comp,
  output logic  last
);

  logic [2:0] r_slot;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot <= 3'd0;
    end else if (clr) begin
      r_slot <= 3'd0;
    end else if (adv) begin
      r_slot <= last ? 3'd0 : r_slot + 3'd1;
    end
  end

  // 4:4:4 -> Y,Cb,Cr ; 4:2:0 -> Y,Y,Y,Y,Cb,Cr
  always_comb begin
    comp = COMP_Y;
    last = 1'b0;
    if (mode == MODE_444) begin
      case (r_slot)
        3'd0:    comp = COMP_Y;
        3'd1:    comp = COMP_CB;
        default: begin
          comp = COMP_CR;
          last = 1'b1;
        end
      endcase
    end else begin
      case (r_slot)
        3'd0, 3'd1, 3'd2, 3'd3: comp = COMP_Y;
        3'd4:    comp = COMP_CB;
        default: begin
          comp = COMP_CR;
          last = 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/jpeg_blk_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_blk_sched : serializes Y/Cb/Cr coefficient blocks in MCU order   |
// | Rev 1.0        : initial release                                      |
// +----------------------------------------------------------------------+
module jpeg_blk_sched
  import jpeg_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int NCOMP = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      frame_go,
  input  logic                      cfg_mode,
  input  logic [CNT_W-1:0]          cfg_mcu_total,
  input  logic [NCOMP-1:0]          blk_req,
  output logic [NCOMP-1:0]          blk_rd,
  input  logic [NCOMP*COEF_W-1:0]   blk_data,
  output logic [NCOMP-1:0]          blk_done,
  input  logic                      ds_ready,
  output logic [COEF_W-1:0]         q_data,
  output logic                      q_data_valid,
  output logic [1:0]                comp_id,
  output logic                      frame_start,
  output logic                      frame_end,
  output logic                      busy
);

  localparam logic [5:0] c_coef_last = 6'(BLK_COEFS - 1);

  logic [2:0]        r_state;
  logic              r_mode;
  logic [CNT_W-1:0]  r_total;
  logic [CNT_W-1:0]  r_mcu;
  logic [5:0]        r_coef;

  comp_t             w_target;
  logic              w_last_slot;
  logic              w_seq_clr;
  logic              w_seq_adv;
  logic [NCOMP-1:0]  w_tgt_1h;
  logic              w_rd_any;
  logic              w_req_hit;
  logic              w_frame_last;
  logic [COEF_W-1:0] w_sel_data;

  assign w_seq_clr = (r_state == ST_START);
  assign w_seq_adv = (r_state == ST_DONE);

  jpeg_mcu_seq u_seq (
    .clk  (clk),
    .rstn (rstn),
    .mode (r_mode),
    .clr  (w_seq_clr),
    .adv  (w_seq_adv),
    .comp (w_target),
    .last (w_last_slot)
  );

  generate
    for (genvar gi = 0; gi < NCOMP; gi++) begin : g_comp
      assign w_tgt_1h[gi] = (w_target == 2'(gi));
    end
  endgenerate

  assign w_rd_any  = (r_state == ST_XFER) && ds_ready;
  assign blk_rd    = w_tgt_1h & {NCOMP{w_rd_any}};
  assign w_req_hit = |(blk_req & w_tgt_1h);
  assign busy      = (r_state != ST_IDLE);

  // Extended by one bit so a total of 2^CNT_W-1 terminates without wrapping
  assign w_frame_last = (({1'b0, r_mcu} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, r_total});

  always_comb begin
    w_sel_data = blk_data[COEF_W-1:0];
    case (w_target)
      COMP_CB: w_sel_data = blk_data[2*COEF_W-1:COEF_W];
      COMP_CR: w_sel_data = blk_data[3*COEF_W-1:2*COEF_W];
      default: w_sel_data = blk_data[COEF_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_444;
      r_total      <= '0;
      r_mcu        <= '0;
      r_coef       <= 6'd0;
      q_data       <= '0;
      q_data_valid <= 1'b0;
      comp_id      <= 2'd0;
      blk_done     <= '0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      q_data_valid <= 1'b0;
      blk_done     <= '0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_go) begin
            r_mode      <= cfg_mode;
            r_total     <= cfg_mcu_total;
            frame_start <= 1'b1;
            r_state     <= ST_START;
          end
        end
        ST_START: begin
          r_mcu <= '0;
          if (r_total == '0) begin
            frame_end <= 1'b1;
            r_state   <= ST_END;
          end else begin
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (w_req_hit) begin
            r_coef  <= 6'd0;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (ds_ready) begin
            q_data       <= w_sel_data;
            q_data_valid <= 1'b1;
            comp_id      <= w_target;
            r_coef       <= r_coef + 6'd1;
            if (r_coef == c_coef_last) begin
              blk_done <= w_tgt_1h;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_ARB;
          if (w_last_slot) begin
            r_mcu <= r_mcu + 1'b1;
            if (w_frame_last) begin
              frame_end <= 1'b1;
              r_state   <= ST_END;
            end
          end
        end
        ST_END: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_blk_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jpeg_blk_sched : directed self-checking bench for jpeg_blk_sched   |
// | Rev 1.0           : initial release                                   |
// +----------------------------------------------------------------------+
module tb_jpeg_blk_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        frame_go = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [15:0] cfg_mcu_total = 16'd0;
  logic [2:0]  blk_req = 3'b000;
  logic [32:0] blk_data;
  logic        ds_ready = 1'b0;
  logic [2:0]  blk_rd;
  logic [2:0]  blk_done;
  logic [10:0] q_data;
  logic        q_data_valid;
  logic [1:0]  comp_id;
  logic        frame_start;
  logic        frame_end;
  logic        busy;

  int checks = 0;
  int errors = 0;

  jpeg_blk_sched #(.CNT_W(16), .NCOMP(3)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .frame_go      (frame_go),
    .cfg_mode      (cfg_mode),
    .cfg_mcu_total (cfg_mcu_total),
    .blk_req       (blk_req),
    .blk_rd        (blk_rd),
    .blk_data      (blk_data),
    .blk_done      (blk_done),
    .ds_ready      (ds_ready),
    .q_data        (q_data),
    .q_data_valid  (q_data_valid),
    .comp_id       (comp_id),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Source model: each component presents (read index mod 64) + comp*100
  int   src_idx [0:2];
  logic src_clr = 1'b0;

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (src_clr)        src_idx[c] <= 0;
      else if (blk_rd[c]) src_idx[c] <= src_idx[c] + 1;
    end
  end

  assign blk_data = {11'(src_idx[2] % 64 + 200), 11'(src_idx[1] % 64 + 100), 11'(src_idx[0] % 64)};

  // Observation recorder (no pass/fail decisions here)
  logic       mon_clr = 1'b0;
  logic       prev_ds = 1'b0;
  int         mcyc = 0;
  int         n_valid, n_pulse, n_blk, n_done, n_fs, n_fe, blk_cnt;
  int         n_bad_data, n_bad_comp, n_bad_done, n_gap_bad, n_rd_bad, n_fs_bad;
  int         last_v_cyc, fs_cyc, fe_cyc;
  logic [1:0] cur_comp;
  logic [1:0] blk_comp [0:7];
  logic [2:0] done_vec [0:7];

  always @(negedge clk) begin
    mcyc    <= mcyc + 1;
    prev_ds <= ds_ready;
    if (mon_clr) begin
      n_valid <= 0; n_pulse <= 0; n_blk <= 0; n_done <= 0; n_fs <= 0; n_fe <= 0;
      blk_cnt <= 0; n_bad_data <= 0; n_bad_comp <= 0; n_bad_done <= 0;
      n_gap_bad <= 0; n_rd_bad <= 0; n_fs_bad <= 0;
      last_v_cyc <= 0; fs_cyc <= 0; fe_cyc <= 0; cur_comp <= 2'd0;
    end else begin
      if (q_data_valid || frame_start || frame_end) n_pulse <= n_pulse + 1;
      if (frame_start) begin
        n_fs   <= n_fs + 1;
        fs_cyc <= mcyc;
        if (q_data_valid) n_fs_bad <= n_fs_bad + 1;
      end
      if (frame_end) begin
        n_fe   <= n_fe + 1;
        fe_cyc <= mcyc;
      end
      if ($countones(blk_rd) > 1 || (|blk_rd && !ds_ready)) n_rd_bad <= n_rd_bad + 1;
      if (q_data_valid) begin
        n_valid    <= n_valid + 1;
        last_v_cyc <= mcyc;
        if (!prev_ds) n_gap_bad <= n_gap_bad + 1;
        if (blk_cnt == 0 || blk_cnt == 64) begin
          blk_cnt  <= 1;
          cur_comp <= comp_id;
          if (n_blk < 8) blk_comp[n_blk] <= comp_id;
          n_blk <= n_blk + 1;
          if (q_data !== 11'(int'(comp_id) * 100)) n_bad_data <= n_bad_data + 1;
        end else begin
          blk_cnt <= blk_cnt + 1;
          if (comp_id !== cur_comp) n_bad_comp <= n_bad_comp + 1;
          if (q_data !== 11'(blk_cnt + int'(cur_comp) * 100)) n_bad_data <= n_bad_data + 1;
        end
      end
      if (|blk_done) begin
        if (n_done < 8) done_vec[n_done] <= blk_done;
        n_done <= n_done + 1;
        if (!(q_data_valid && blk_cnt == 63)) n_bad_done <= n_bad_done + 1;
      end
    end
  end

  task automatic clear_all();
    @(posedge clk); #1;
    src_clr = 1'b1;
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    src_clr = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic start_frame(input logic m, input logic [15:0] t);
    @(posedge clk); #1;
    frame_go      = 1'b1;
    cfg_mode      = m;
    cfg_mcu_total = t;
    @(posedge clk); #1;
    frame_go = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({blk_rd, blk_done, q_data, q_data_valid, comp_id, frame_start, frame_end, busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b done=%b q=%0d v=%b id=%0d fs=%b fe=%b busy=%b, want all 0",
               blk_rd, blk_done, q_data, q_data_valid, comp_id, frame_start, frame_end, busy);
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_444();
    blk_req  = 3'b111;
    ds_ready = 1'b1;
    clear_all();
    start_frame(1'b0, 16'd2);
    for (int i = 0; i < 2000 && n_fe == 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (n_fe !== 1 || n_fs !== 1) begin
      errors++;
      $display("FAIL t444_frame_pulses: got fs=%0d fe=%0d want 1 1", n_fs, n_fe);
    end
    checks++;
    if (n_valid !== 384 || n_pulse !== 386) begin
      errors++;
      $display("FAIL t444_counts: got valid=%0d pulse=%0d want 384 386", n_valid, n_pulse);
    end
    checks++;
    if (n_blk !== 6 || {blk_comp[0], blk_comp[1], blk_comp[2], blk_comp[3], blk_comp[4], blk_comp[5]} !== 12'b00_01_10_00_01_10) begin
      errors++;
      $display("FAIL t444_comp_seq: got n=%0d %0d%0d%0d%0d%0d%0d want 6 012012", n_blk,
               blk_comp[0], blk_comp[1], blk_comp[2], blk_comp[3], blk_comp[4], blk_comp[5]);
    end
    checks++;
    if (n_done !== 6 || n_bad_done !== 0 ||
        {done_vec[0], done_vec[1], done_vec[2], done_vec[3], done_vec[4], done_vec[5]} !== 18'b001_010_100_001_010_100) begin
      errors++;
      $display("FAIL t444_blk_done: got n=%0d bad=%0d want 6 in order Y,Cb,Cr x2 with 0 bad", n_done, n_bad_done);
    end
    checks++;
    if (fe_cyc !== last_v_cyc + 1 || n_fs_bad !== 0) begin
      errors++;
      $display("FAIL t444_fe_timing: got fe_cyc=%0d last_valid=%0d fs_overlap=%0d want fe=last+1, 0",
               fe_cyc, last_v_cyc, n_fs_bad);
    end
    checks++;
    if (n_bad_data !== 0 || n_bad_comp !== 0 || n_rd_bad !== 0) begin
      errors++;
      $display("FAIL t444_data: got bad_data=%0d bad_comp=%0d bad_rd=%0d want 0 0 0", n_bad_data, n_bad_comp, n_rd_bad);
    end
    checks++;
    if (src_idx[0] !== 128 || src_idx[1] !== 128 || src_idx[2] !== 128 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t444_reads: got %0d %0d %0d busy=%b want 128 128 128 0", src_idx[0], src_idx[1], src_idx[2], busy);
    end
  endtask

  task automatic test_420();
    blk_req  = 3'b111;
    ds_ready = 1'b1;
    clear_all();
    start_frame(1'b1, 16'd1);
    for (int i = 0; i < 2000 && n_fe == 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (n_fe !== 1 || n_valid !== 384) begin
      errors++;
      $display("FAIL t420_frame: got fe=%0d valid=%0d want 1 384", n_fe, n_valid);
    end
    checks++;
    if (n_blk !== 6 || {blk_comp[0], blk_comp[1], blk_comp[2], blk_comp[3], blk_comp[4], blk_comp[5]} !== 12'b00_00_00_00_01_10) begin
      errors++;
      $display("FAIL t420_comp_seq: got n=%0d %0d%0d%0d%0d%0d%0d want 6 000012", n_blk,
               blk_comp[0], blk_comp[1], blk_comp[2], blk_comp[3], blk_comp[4], blk_comp[5]);
    end
    checks++;
    if (src_idx[0] !== 256 || src_idx[1] !== 64 || src_idx[2] !== 64) begin
      errors++;
      $display("FAIL t420_reads: got %0d %0d %0d want 256 64 64", src_idx[0], src_idx[1], src_idx[2]);
    end
    checks++;
    if (n_bad_data !== 0 || n_bad_comp !== 0 || n_bad_done !== 0) begin
      errors++;
      $display("FAIL t420_data: got bad_data=%0d bad_comp=%0d bad_done=%0d want 0 0 0", n_bad_data, n_bad_comp, n_bad_done);
    end
  endtask

  task automatic test_ds_toggle();
    blk_req  = 3'b111;
    ds_ready = 1'b1;
    clear_all();
    start_frame(1'b0, 16'd1);
    for (int i = 0; i < 3000 && n_fe == 0; i++) begin
      @(posedge clk); #1;
      ds_ready = ~ds_ready;
    end
    ds_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (n_fe !== 1 || n_valid !== 192 || n_blk !== 3) begin
      errors++;
      $display("FAIL toggle_counts: got fe=%0d valid=%0d blks=%0d want 1 192 3", n_fe, n_valid, n_blk);
    end
    checks++;
    if (n_gap_bad !== 0 || n_rd_bad !== 0) begin
      errors++;
      $display("FAIL toggle_gaps: got valid_after_low=%0d rd_while_low=%0d want 0 0", n_gap_bad, n_rd_bad);
    end
    checks++;
    if (n_done !== 3 || n_bad_done !== 0 || n_bad_data !== 0) begin
      errors++;
      $display("FAIL toggle_done: got done=%0d bad_done=%0d bad_data=%0d want 3 0 0", n_done, n_bad_done, n_bad_data);
    end
  endtask

  task automatic test_req_stall();
    blk_req  = 3'b101;
    ds_ready = 1'b1;
    clear_all();
    start_frame(1'b0, 16'd1);
    for (int i = 0; i < 500 && n_done == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (src_idx[0] !== 64 || src_idx[1] !== 0 || src_idx[2] !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: got reads %0d %0d %0d busy=%b want 64 0 0 1", src_idx[0], src_idx[1], src_idx[2], busy);
    end
    @(posedge clk); #1 blk_req = 3'b111;
    for (int i = 0; i < 1000 && n_fe == 0; i++) @(negedge clk);
    checks++;
    if (n_fe !== 1 || n_blk !== 3 || blk_comp[1] !== 2'd1 || blk_comp[2] !== 2'd2) begin
      errors++;
      $display("FAIL stall_order: got fe=%0d blks=%0d b1=%0d b2=%0d want 1 3 1 2", n_fe, n_blk, blk_comp[1], blk_comp[2]);
    end
  endtask

  task automatic test_zero_total();
    blk_req  = 3'b111;
    ds_ready = 1'b1;
    clear_all();
    start_frame(1'b0, 16'd0);
    repeat (5) @(negedge clk);
    checks++;
    if (n_fs !== 1 || n_fe !== 1 || fe_cyc !== fs_cyc + 1) begin
      errors++;
      $display("FAIL zero_pulses: got fs=%0d fe=%0d fs_cyc=%0d fe_cyc=%0d want 1 1 fe=fs+1", n_fs, n_fe, fs_cyc, fe_cyc);
    end
    checks++;
    if (src_idx[0] + src_idx[1] + src_idx[2] !== 0 || busy !== 1'b0 || n_valid !== 0) begin
      errors++;
      $display("FAIL zero_idle: got reads=%0d valid=%0d busy=%b want 0 0 0",
               src_idx[0] + src_idx[1] + src_idx[2], n_valid, busy);
    end
  endtask

  task automatic test_reset_midframe();
    blk_req  = 3'b111;
    ds_ready = 1'b1;
    clear_all();
    start_frame(1'b0, 16'd1);
    for (int i = 0; i < 1000 && src_idx[1] < 30; i++) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({blk_rd, blk_done, q_data, q_data_valid, comp_id, frame_start, frame_end, busy} !== 23'd0 || src_idx[1] !== 30) begin
      errors++;
      $display("FAIL midreset_outputs: got rd=%b v=%b q=%0d id=%0d busy=%b cb_reads=%0d want all 0, 30",
               blk_rd, q_data_valid, q_data, comp_id, busy, src_idx[1]);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (n_fe !== 0) begin
      errors++;
      $display("FAIL midreset_no_fe: got fe=%0d want 0", n_fe);
    end
    clear_all();
    start_frame(1'b0, 16'd1);
    for (int i = 0; i < 1000 && n_fe == 0; i++) @(negedge clk);
    checks++;
    if (n_fs !== 1 || n_fe !== 1 || n_blk !== 3 || blk_comp[0] !== 2'd0 || n_bad_data !== 0) begin
      errors++;
      $display("FAIL midreset_restart: got fs=%0d fe=%0d blks=%0d first=%0d bad_data=%0d want 1 1 3 0 0",
               n_fs, n_fe, n_blk, blk_comp[0], n_bad_data);
    end
  endtask

  initial begin
    test_reset();
    test_444();
    test_420();
    test_ds_toggle();
    test_req_stall();
    test_zero_total();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
